// File: rtl/dpram_be_clr_if.sv
// Port bundle for dpram_be_clr: clear control plus the two RAM access ports.
// The master side drives requests and the slave side (the RAM) returns
// BUSY and the two read-data buses.
interface dpram_be_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) ();

    localparam int NBYTES = DATA_WIDTH / 8;

    // Clear sequencer control
    logic                  CLR_REQ;
    logic                  BUSY;

    // Port A
    logic                  CEA;
    logic [NBYTES-1:0]     WEA;
    logic [ADDR_WIDTH-1:0] ADDRA;
    logic [DATA_WIDTH-1:0] DIA;
    logic [DATA_WIDTH-1:0] DOA;

    // Port B
    logic                  CEB;
    logic [NBYTES-1:0]     WEB;
    logic [ADDR_WIDTH-1:0] ADDRB;
    logic [DATA_WIDTH-1:0] DIB;
    logic [DATA_WIDTH-1:0] DOB;

    modport master (
        output CLR_REQ,
        output CEA, WEA, ADDRA, DIA,
        output CEB, WEB, ADDRB, DIB,
        input  BUSY, DOA, DOB
    );

    modport slave (
        input  CLR_REQ,
        input  CEA, WEA, ADDRA, DIA,
        input  CEB, WEB, ADDRB, DIB,
        output BUSY, DOA, DOB
    );

endinterface

// File: rtl/dpram_be_clr.sv
// dpram_be_clr: single-clock true dual-port RAM with per-byte write enables,
// write-first same-port reads, read-first cross-port reads, port A priority
// on colliding lanes, and a zero-fill clear sequencer that reports BUSY.
//
// Optional build macro DPRAM_OUTREG_EN adds one output pipeline register on
// DOA/DOB (read latency 2). Without it the read latency is 1.
module dpram_be_clr #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 13,
    parameter int INIT_ON_RESET = 1
) (
    input  logic               CLK,
    input  logic               RST,
    dpram_be_clr_if.slave      bus
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Storage array; never reset, only zero-filled by the sequencer.
    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Sequencer state
    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_s;
    logic                  busy_r;

    // Port qualification and write-lane decode
    logic                  idle_s;
    logic                  port_a_on_s;
    logic                  port_b_on_s;
    logic [NBYTES-1:0]     we_a_s;
    logic [NBYTES-1:0]     we_b_s;
    logic [NBYTES-1:0]     we_b_at_a_s;
    logic [NBYTES-1:0]     we_a_at_b_s;

    // Read-path words
    logic [DATA_WIDTH-1:0] old_a_s;
    logic [DATA_WIDTH-1:0] old_b_s;
    logic [DATA_WIDTH-1:0] final_a_s;
    logic [DATA_WIDTH-1:0] final_b_s;
    logic [DATA_WIDTH-1:0] rd_a_s;
    logic [DATA_WIDTH-1:0] rd_b_s;

    // First-level output registers
    logic [DATA_WIDTH-1:0] doa_r;
    logic [DATA_WIDTH-1:0] dob_r;

    // Lane-wise merge: the high-priority writer wins a lane, then the
    // low-priority writer, otherwise the stored lane is kept.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] hi_data,
        input logic [NBYTES-1:0]     hi_we,
        input logic [DATA_WIDTH-1:0] lo_data,
        input logic [NBYTES-1:0]     lo_we
    );
        logic [DATA_WIDTH-1:0] word;
        word = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (hi_we[i]) begin
                word[8*i +: 8] = hi_data[8*i +: 8];
            end else if (lo_we[i]) begin
                word[8*i +: 8] = lo_data[8*i +: 8];
            end else begin
                word[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return word;
    endfunction

    // Sequencer next state: IDLE accepts a clear request, CLEAR walks cnt
    // through every address and returns to IDLE after the last one.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.CLR_REQ) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
                cnt_s = {ADDR_WIDTH{1'b0}};
            end
            ST_CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_s = ST_CLEAR;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = RESET_STATE;
                cnt_s   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Sequencer registers; BUSY is registered from the next state so it
    // rises and falls on the same edge as the state change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= RESET_STATE;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
            busy_r  <= (RESET_STATE == ST_CLEAR);
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_CLEAR);
        end
    end

    // Port gating, collision decode and the words each port will return.
    // A port that writes sees the final stored word (including the other
    // port's merged lanes); a port that only reads sees the old word.
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        port_a_on_s = idle_s && bus.CEA;
        port_b_on_s = idle_s && bus.CEB;

        if (port_a_on_s) begin
            we_a_s = bus.WEA;
        end else begin
            we_a_s = {NBYTES{1'b0}};
        end

        if (port_b_on_s) begin
            we_b_s = bus.WEB;
        end else begin
            we_b_s = {NBYTES{1'b0}};
        end

        if (bus.ADDRA == bus.ADDRB) begin
            we_b_at_a_s = we_b_s;
            we_a_at_b_s = we_a_s;
        end else begin
            we_b_at_a_s = {NBYTES{1'b0}};
            we_a_at_b_s = {NBYTES{1'b0}};
        end

        old_a_s   = mem_r[bus.ADDRA];
        old_b_s   = mem_r[bus.ADDRB];
        final_a_s = lane_merge(old_a_s, bus.DIA, we_a_s, bus.DIB, we_b_at_a_s);
        final_b_s = lane_merge(old_b_s, bus.DIA, we_a_at_b_s, bus.DIB, we_b_s);

        if (|we_a_s) begin
            rd_a_s = final_a_s;
        end else begin
            rd_a_s = old_a_s;
        end

        if (|we_b_s) begin
            rd_b_s = final_b_s;
        end else begin
            rd_b_s = old_b_s;
        end
    end

    // Array update: zero-fill during CLEAR, otherwise byte-lane port writes
    // with port A issued last so it owns any lane both ports write.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_r == ST_CLEAR) begin
                mem_r[cnt_r] <= {DATA_WIDTH{1'b0}};
            end else begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (we_b_s[i]) begin
                        mem_r[bus.ADDRB][8*i +: 8] <= bus.DIB[8*i +: 8];
                    end
                end
                for (int i = 0; i < NBYTES; i++) begin
                    if (we_a_s[i]) begin
                        mem_r[bus.ADDRA][8*i +: 8] <= bus.DIA[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read-data registers: load only on an enabled IDLE cycle, else hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            doa_r <= {DATA_WIDTH{1'b0}};
            dob_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (port_a_on_s) begin
                doa_r <= rd_a_s;
            end
            if (port_b_on_s) begin
                dob_r <= rd_b_s;
            end
        end
    end

`ifdef DPRAM_OUTREG_EN
    // Second output stage and the enables that mark a fresh first stage.
    logic                  load_a_r;
    logic                  load_b_r;
    logic [DATA_WIDTH-1:0] doa_q_r;
    logic [DATA_WIDTH-1:0] dob_q_r;

    // Pipeline stage: capture the first stage one cycle after an enabled
    // IDLE access, hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_a_r <= 1'b0;
            load_b_r <= 1'b0;
            doa_q_r  <= {DATA_WIDTH{1'b0}};
            dob_q_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            load_a_r <= port_a_on_s;
            load_b_r <= port_b_on_s;
            if (load_a_r) begin
                doa_q_r <= doa_r;
            end
            if (load_b_r) begin
                dob_q_r <= dob_r;
            end
        end
    end

    assign bus.DOA = doa_q_r;
    assign bus.DOB = dob_q_r;
`else
    assign bus.DOA = doa_r;
    assign bus.DOB = dob_r;
`endif

    assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed testbench for dpram_be_clr (DATA_WIDTH=32, ADDR_WIDTH=4,
// INIT_ON_RESET=1). Expected read data is queued when a read is issued and
// compared when it is due at the port output.
module tb_dpram_be_clr;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    dpram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpram_be_clr #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .INIT_ON_RESET (1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            check(e.tag, bus.DOA, e.val);
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            check(e.tag, bus.DOB, e.val);
        end
    endtask

    task automatic push_a(input logic [31:0] v, input string tag);
        qa.push_back('{cyc + LAT, v, tag});
    endtask

    task automatic push_b(input logic [31:0] v, input string tag);
        qb.push_back('{cyc + LAT, v, tag});
    endtask

    task automatic port_a(input logic ce, input logic [3:0] we, input logic [3:0] addr, input logic [31:0] di);
        bus.CEA   = ce;
        bus.WEA   = we;
        bus.ADDRA = addr;
        bus.DIA   = di;
    endtask

    task automatic port_b(input logic ce, input logic [3:0] we, input logic [3:0] addr, input logic [31:0] di);
        bus.CEB   = ce;
        bus.WEB   = we;
        bus.ADDRB = addr;
        bus.DIB   = di;
    endtask

    initial begin
        // Reset
        rst         = 1'b1;
        bus.CLR_REQ = 1'b0;
        port_a(1'b0, 4'h0, 4'h0, 32'h0);
        port_b(1'b0, 4'h0, 4'h0, 32'h0);
        repeat (3) tick();
        check("reset_busy", 32'(bus.BUSY), 32'd1);
        check("reset_doa", bus.DOA, 32'h0);
        check("reset_dob", bus.DOB, 32'h0);

        // Power-on clear with ports hammering writes that must be ignored
        rst = 1'b0;
        port_a(1'b1, 4'hF, 4'd1, 32'hFFFF_FFFF);
        port_b(1'b1, 4'hF, 4'd2, 32'hFFFF_FFFF);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 40) begin
            check("clr_doa_zero", bus.DOA, 32'h0);
            n++;
            tick();
        end
        check("init_busy_cycles", 32'(n), 32'(DEPTH));

        // Every address reads zero after the clear
        for (int i = 0; i < DEPTH; i++) begin
            port_a(1'b1, 4'h0, 4'(i), 32'h0);
            port_b(1'b1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
            push_a(32'h0, "clr_rd_a");
            push_b(32'h0, "clr_rd_b");
            tick();
        end
        port_a(1'b0, 4'h0, 4'h0, 32'h0);
        port_b(1'b0, 4'h0, 4'h0, 32'h0);
        repeat (LAT) tick();

        // Partial byte write with write-first readback
        port_a(1'b1, 4'hF, 4'd5, 32'hAAAA_AAAA);
        push_a(32'hAAAA_AAAA, "wr5_full");
        tick();
        port_a(1'b1, 4'b0101, 4'd5, 32'h1122_3344);
        push_a(32'hAA22_AA44, "wf5_partial");
        tick();
        port_a(1'b1, 4'h0, 4'd5, 32'h0);
        push_a(32'hAA22_AA44, "rd5");
        tick();

        // Same-address collision: A owns lane 0, B's lane 1 lands
        port_a(1'b1, 4'b0001, 4'd3, 32'h0000_00FF);
        port_b(1'b1, 4'b0011, 4'd3, 32'h0000_EE00);
        push_a(32'h0000_EEFF, "col3_doa");
        push_b(32'h0000_EEFF, "col3_dob");
        tick();
        port_a(1'b0, 4'h0, 4'd0, 32'h0);
        port_b(1'b1, 4'h0, 4'd3, 32'h0);
        push_b(32'h0000_EEFF, "rd3");
        tick();

        // Cross-port read during write returns old data
        port_b(1'b1, 4'hF, 4'd7, 32'h1234_5678);
        push_b(32'h1234_5678, "wr7");
        tick();
        port_a(1'b1, 4'hF, 4'd7, 32'hCAFE_F00D);
        port_b(1'b1, 4'h0, 4'd7, 32'h0);
        push_a(32'hCAFE_F00D, "wf7_doa");
        push_b(32'h1234_5678, "xrd7_old");
        tick();
        port_a(1'b0, 4'h0, 4'd0, 32'h0);
        port_b(1'b1, 4'h0, 4'd7, 32'h0);
        push_b(32'hCAFE_F00D, "rd7_new");
        tick();

        // Disabled ports: outputs hold and write enables do nothing
        port_a(1'b0, 4'hF, 4'd5, 32'h0);
        port_b(1'b0, 4'hF, 4'd7, 32'h0);
        repeat (3) tick();
        check("hold_doa", bus.DOA, 32'hCAFE_F00D);
        check("hold_dob", bus.DOB, 32'hCAFE_F00D);
        port_a(1'b1, 4'h0, 4'd5, 32'h0);
        port_b(1'b1, 4'h0, 4'd7, 32'h0);
        push_a(32'hAA22_AA44, "nowr5");
        push_b(32'hCAFE_F00D, "nowr7");
        tick();

        // Address 2 write then read (latency check)
        port_b(1'b0, 4'h0, 4'd0, 32'h0);
        port_a(1'b1, 4'hF, 4'd2, 32'h5A5A_5A5A);
        push_a(32'h5A5A_5A5A, "wr2");
        tick();
        port_a(1'b1, 4'h0, 4'd2, 32'h0);
        push_a(32'h5A5A_5A5A, "rd2");
        tick();
        port_a(1'b0, 4'h0, 4'd0, 32'h0);
        repeat (LAT) tick();
        check("hold2_doa", bus.DOA, 32'h5A5A_5A5A);

        // Clear request together with a write; second request ignored
        port_a(1'b1, 4'hF, 4'd9, 32'h0000_0099);
        push_a(32'h0000_0099, "clr_wr9");
        bus.CLR_REQ = 1'b1;
        tick();
        bus.CLR_REQ = 1'b0;
        check("clr_busy_rise", 32'(bus.BUSY), 32'd1);
        port_a(1'b1, 4'hF, 4'd4, 32'hDEAD_BEEF);
        port_b(1'b1, 4'hF, 4'd6, 32'hDEAD_BEEF);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 40) begin
            bus.CLR_REQ = (n == 3);
            n++;
            tick();
        end
        bus.CLR_REQ = 1'b0;
        check("req_busy_cycles", 32'(n), 32'(DEPTH));
        port_a(1'b1, 4'h0, 4'd4, 32'h0);
        port_b(1'b1, 4'h0, 4'd6, 32'h0);
        push_a(32'h0, "noland4");
        push_b(32'h0, "noland6");
        tick();
        port_a(1'b1, 4'h0, 4'd9, 32'h0);
        port_b(1'b1, 4'h0, 4'd7, 32'h0);
        push_a(32'h0, "cleared9");
        push_b(32'h0, "cleared7");
        tick();
        port_a(1'b0, 4'h0, 4'd0, 32'h0);
        port_b(1'b0, 4'h0, 4'd0, 32'h0);
        repeat (LAT) tick();

        // Reset mid-clear restarts the full sequence
        bus.CLR_REQ = 1'b1;
        tick();
        bus.CLR_REQ = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(bus.BUSY), 32'd1);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("rst_restart_cycles", 32'(n), 32'(DEPTH));

        repeat (3) tick();
        check("queue_a_drained", 32'(qa.size()), 32'd0);
        check("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
